// File: rtl/uart_pkg.sv
// Shared definitions for the UART CSR bank: register addresses, interrupt and
// error bit positions, RXDATA read-sequencer states and the baud divisor reset value.
package uart_pkg;

  localparam logic [3:0] ADDR_TXDATA  = 4'd0;
  localparam logic [3:0] ADDR_RXDATA  = 4'd1;
  localparam logic [3:0] ADDR_TXCTRL  = 4'd2;
  localparam logic [3:0] ADDR_RXCTRL  = 4'd3;
  localparam logic [3:0] ADDR_IE      = 4'd4;
  localparam logic [3:0] ADDR_IP      = 4'd5;
  localparam logic [3:0] ADDR_DIV     = 4'd6;
  localparam logic [3:0] ADDR_FRAME   = 4'd7;
  localparam logic [3:0] ADDR_ERRSTAT = 4'd8;
  localparam logic [3:0] ADDR_LEVEL   = 4'd9;
  localparam logic [3:0] ADDR_TIMEOUT = 4'd10;

  // IE and IP share one bit layout
  localparam int IRQ_TXWM    = 0;
  localparam int IRQ_RXWM    = 1;
  localparam int IRQ_RXERR   = 2;
  localparam int IRQ_TIMEOUT = 3;

  localparam int ERR_FRAME   = 0;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_OVERRUN = 2;
  localparam int ERR_TXDROP  = 3;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_POP  = 2'd1,
    RD_CAP  = 2'd2
  } rd_state_e;

  function automatic logic [15:0] div_init(input int clock_freq_hz);
    return 16'(clock_freq_hz / 115200 - 1);
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// RX idle timeout: a prescaler of div+1 clocks per bit period feeds a bit counter;
// hit pulses once when the count reaches timeout, then the count holds until cleared.
module uart_rx_timeout (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] div,
  input  logic [7:0]  timeout,
  input  logic        clear,
  output logic        hit
);

  logic [15:0] presc_q;
  logic [7:0]  bits_q;
  logic        tick;
  logic        expired;

  // A zero timeout is always "expired", so nothing counts and hit never fires
  assign expired = (bits_q >= timeout);
  assign tick    = (presc_q >= div);
  assign hit     = tick && !expired && (({1'b0, bits_q} + 9'd1) == {1'b0, timeout});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      bits_q  <= '0;
    end else if (clear) begin
      presc_q <= '0;
      bits_q  <= '0;
    end else if (!expired) begin
      if (tick) begin
        presc_q <= '0;
        bits_q  <= bits_q + 8'd1;
      end else begin
        presc_q <= presc_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_csr_bank.sv
// UART control/status register bank: configuration registers, sticky error and
// interrupt status, TX push path and a three-state sequencer for RXDATA pops.
module uart_csr_bank
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int CLOCK_FREQ_HZ = 10000000,
  parameter int TIMEOUT_INIT  = 40,
  localparam int LW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    addr,
  input  logic [31:0]   wr_data,
  input  logic          bank_rd_en,
  input  logic          bank_wr_en,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          bank_ready,
  output logic          interrupt,
  output logic          txen,
  output logic          rxen,
  output logic          nstop,
  output logic          parity_en,
  output logic          parity_odd,
  output logic [1:0]    data_bits,
  output logic [15:0]   div,
  output logic          tx_fifo_wr_en,
  output logic [7:0]    tx_fifo_wr_data,
  output logic          rx_fifo_rd_en,
  input  logic [7:0]    rx_fifo_rd_data,
  input  logic          tx_fifo_full,
  input  logic          rx_fifo_empty,
  input  logic [LW-1:0] tx_level,
  input  logic [LW-1:0] rx_level,
  input  logic          rx_byte_done,
  input  logic          rx_frame_err,
  input  logic          rx_parity_err,
  input  logic          rx_overrun,
  output rd_state_e     rd_state
);

  localparam logic [15:0] DivInit = div_init(CLOCK_FREQ_HZ);

  // Handshake: an access is taken on any clock edge where its strobe and
  // bank_ready are both high; a read answers with a one-cycle rd_valid.
  rd_state_e   state_q, state_d;
  logic        cap;
  logic        rd_acc, wr_acc;
  logic [31:0] rd_mux;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic [LW-1:0] txcnt_q, rxcnt_q;
  logic [3:0]  ie_q, errstat_q, err_set, err_clr, ip;
  logic        ip_to_q, to_hit, to_clr;
  logic [7:0]  timeout_q;
  logic        txdrop, txpush;
  logic        unused_wr_bits;

  assign unused_wr_bits = ^wr_data[31:16+LW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bank_ready    = 1'b0;
    rx_fifo_rd_en = 1'b0;
    cap           = 1'b0;
    case (state_q)
      RD_IDLE: begin
        bank_ready = 1'b1;
        if (bank_rd_en && addr == ADDR_RXDATA && !rx_fifo_empty) state_d = RD_POP;
      end
      RD_POP: begin
        rx_fifo_rd_en = 1'b1;
        state_d       = RD_CAP;
      end
      RD_CAP: begin
        cap     = 1'b1;
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign rd_state = state_q;
  assign rd_acc   = bank_rd_en && bank_ready;
  assign wr_acc   = bank_wr_en && bank_ready;
  assign txpush   = wr_acc && addr == ADDR_TXDATA && !tx_fifo_full;
  assign txdrop   = wr_acc && addr == ADDR_TXDATA && tx_fifo_full;

  assign err_set = {txdrop, rx_overrun, rx_parity_err, rx_frame_err};
  assign err_clr = (wr_acc && addr == ADDR_ERRSTAT) ? wr_data[3:0] : 4'd0;
  assign to_clr  = wr_acc && addr == ADDR_IP && wr_data[IRQ_TIMEOUT];

  always_comb begin
    ip              = '0;
    ip[IRQ_TXWM]    = tx_level < txcnt_q;
    ip[IRQ_RXWM]    = rx_level > rxcnt_q;
    ip[IRQ_RXERR]   = |errstat_q;
    ip[IRQ_TIMEOUT] = ip_to_q;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_TXDATA:  rd_mux[31] = tx_fifo_full;
      ADDR_TXCTRL:  begin rd_mux[0] = txen; rd_mux[1] = nstop; rd_mux[16+:LW] = txcnt_q; end
      ADDR_RXCTRL:  begin rd_mux[0] = rxen; rd_mux[16+:LW] = rxcnt_q; end
      ADDR_IE:      rd_mux[3:0] = ie_q;
      ADDR_IP:      rd_mux[3:0] = ip;
      ADDR_DIV:     rd_mux[15:0] = div;
      ADDR_FRAME:   rd_mux[3:0] = {parity_odd, parity_en, data_bits};
      ADDR_ERRSTAT: rd_mux[3:0] = errstat_q;
      ADDR_LEVEL:   begin rd_mux[16+:LW] = rx_level; rd_mux[0+:LW] = tx_level; end
      ADDR_TIMEOUT: rd_mux[7:0] = timeout_q;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txen <= 1'b0; nstop <= 1'b0; rxen <= 1'b0;
      txcnt_q <= '0; rxcnt_q <= '0; ie_q <= '0;
      parity_en <= 1'b0; parity_odd <= 1'b0;
      data_bits <= 2'd3;
      div       <= DivInit;
      timeout_q <= 8'(TIMEOUT_INIT);
    end else if (wr_acc) begin
      case (addr)
        ADDR_TXCTRL:  begin txen <= wr_data[0]; nstop <= wr_data[1]; txcnt_q <= wr_data[16+:LW]; end
        ADDR_RXCTRL:  begin rxen <= wr_data[0]; rxcnt_q <= wr_data[16+:LW]; end
        ADDR_IE:      ie_q <= wr_data[3:0];
        ADDR_DIV:     div <= wr_data[15:0];
        ADDR_FRAME:   begin data_bits <= wr_data[1:0]; parity_en <= wr_data[2]; parity_odd <= wr_data[3]; end
        ADDR_TIMEOUT: timeout_q <= wr_data[7:0];
        default: ;
      endcase
    end
  end

  // Sticky status: a set arriving with its clear wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      errstat_q       <= '0;
      ip_to_q         <= 1'b0;
      interrupt       <= 1'b0;
      tx_fifo_wr_en   <= 1'b0;
      tx_fifo_wr_data <= '0;
    end else begin
      errstat_q     <= (errstat_q & ~err_clr) | err_set;
      ip_to_q       <= (ip_to_q & ~to_clr) | to_hit;
      interrupt     <= |(ip & ie_q);
      tx_fifo_wr_en <= txpush;
      if (txpush) tx_fifo_wr_data <= wr_data[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (rd_acc && addr == ADDR_RXDATA) begin
        if (rx_fifo_empty) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= 32'h8000_0000;
        end
      end else if (rd_acc) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= rd_mux;
      end else if (cap) begin
        rd_data_q <= {24'd0, rx_fifo_rd_data};
      end
    end
  end

  // Popped byte is presented straight from the FIFO read port during CAP
  assign rd_valid = rd_valid_q || cap;
  assign rd_data  = cap ? {24'd0, rx_fifo_rd_data} : rd_data_q;

  uart_rx_timeout u_rx_timeout (
    .clock   (clock),
    .reset   (reset),
    .div     (div),
    .timeout (timeout_q),
    .clear   (rx_byte_done || rx_fifo_rd_en || rx_fifo_empty),
    .hit     (to_hit)
  );

endmodule
